// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the MEM stage and a word-wide data memory port.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned half/word requests instead of forcing alignment.
module lsu_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;

  logic [1:0]  req_off;
  logic        req_err;
  logic [31:0] lane_sh, load_val, lane_mask, lane_data, merge_val;

  // Request decode: error detection and the effective lane offset
  always_comb begin
    req_off = req_addr[1:0];
    req_err = (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_size == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
    if (req_size == 2'b01) req_off[0] = 1'b0;
    if (req_size[1]) req_off = 2'b00;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                 state_d = RESP;
          else if (!req_write)         state_d = LOAD;
          else if (req_size == 2'b10)  state_d = STORE;
          else                         state_d = RMW_RD;
        end
      end
      LOAD, STORE, RMW_WR: state_d = RESP;
      RMW_RD:              state_d = RMW_WR;
      RESP:                state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    lane_sh = mem_read_data >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_val = {{24{signed_q & lane_sh[7]}}, lane_sh[7:0]};
      2'b01:   load_val = {{16{signed_q & lane_sh[15]}}, lane_sh[15:0]};
      default: load_val = lane_sh;
    endcase
    lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << {off_q, 3'b000};
    lane_data = {16'h0000, wdata_q} << {off_q, 3'b000};
    merge_val = (mem_read_data & ~lane_mask) | (lane_data & lane_mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      size_q         <= '0;
      signed_q       <= 1'b0;
      off_q          <= '0;
      wdata_q        <= '0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            size_q   <= req_size;
            signed_q <= req_signed;
            off_q    <= req_off;
            wdata_q  <= req_wdata[15:0];
            resp_err <= req_err;
            mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (req_write && req_size == 2'b10 && !req_err) mem_write_data <= req_wdata;
          end
        end
        LOAD:   resp_rdata     <= load_val;
        RMW_RD: mem_write_data <= merge_val;
        RESP: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready    = (state_q == IDLE);
    resp_valid   = (state_q == RESP);
    mem_read_en  = (state_q == LOAD)  || (state_q == RMW_RD);
    mem_write_en = (state_q == STORE) || (state_q == RMW_WR);
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl against a byte-array memory reference model.
module tb_lsu_mem_ctrl;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_read_en    (mem_read_en),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Memory attached to the DUT: combinational read, write on the rising edge
  logic [31:0] mem [64];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  assign mem_read_data = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (pre_we)            mem[pre_idx] <= pre_data;
    else if (mem_write_en) mem[mem_addr[7:2]] <= mem_write_data;
  end

  // Reference model: plain little-endian byte array
  logic [7:0] ref_bytes [256];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [5:0] i);
    return {ref_bytes[{i, 2'd3}], ref_bytes[{i, 2'd2}], ref_bytes[{i, 2'd1}], ref_bytes[{i, 2'd0}]};
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready_wait", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd);
    logic        err;
    logic [7:0]  a;
    logic [5:0]  idx;
    logic [31:0] exp_rd, exp_word, exp_maddr;
    int          exp_lat, exp_reads, exp_writes;
    int          lat, reads, writes;
    logic        seen;

    err = (sz == 2'b11) ||
          (TRAP && ((sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)));
    a = addr[7:0];
    if (sz == 2'b01) a[0] = 1'b0;
    if (sz == 2'b10) a[1:0] = 2'b00;
    idx = a[7:2];
    exp_maddr = {addr[31:2], 2'b00};

    exp_rd = '0;
    if (!err && !wr) begin
      case (sz)
        2'b00: begin
          exp_rd = {24'b0, ref_bytes[a]};
          if (sg && ref_bytes[a][7]) exp_rd[31:8] = '1;
        end
        2'b01: begin
          exp_rd = {16'b0, ref_bytes[a + 8'd1], ref_bytes[a]};
          if (sg && exp_rd[15]) exp_rd[31:16] = '1;
        end
        default: exp_rd = {ref_bytes[a + 8'd3], ref_bytes[a + 8'd2], ref_bytes[a + 8'd1], ref_bytes[a]};
      endcase
    end
    if (!err && wr) begin
      ref_bytes[a] = wd[7:0];
      if (sz != 2'b00) ref_bytes[a + 8'd1] = wd[15:8];
      if (sz == 2'b10) begin
        ref_bytes[a + 8'd2] = wd[23:16];
        ref_bytes[a + 8'd3] = wd[31:24];
      end
    end
    exp_word   = ref_word(idx);
    exp_lat    = err ? 1 : (wr ? ((sz == 2'b10) ? 2 : 3) : 2);
    exp_reads  = (!err && (!wr || sz != 2'b10)) ? 1 : 0;
    exp_writes = (!err && wr) ? 1 : 0;

    wait_ready();
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr;  req_wdata = wd;
    @(posedge clk);
    #1;
    // Scramble the request bus after acceptance: it must be ignored
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

    lat = 0; reads = 0; writes = 0; seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      lat++;
      check_eq("ready_busy", {31'b0, req_ready}, 32'd0);
      if (mem_read_en) begin
        reads++;
        check_eq("rd_addr", mem_addr, exp_maddr);
      end
      if (mem_write_en) begin
        writes++;
        check_eq("wr_addr", mem_addr, exp_maddr);
        check_eq("wr_data", mem_write_data, exp_word);
      end
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("resp_seen", {31'b0, seen}, 32'd1);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("resp_rdata", resp_rdata, exp_rd);
    check_eq("resp_err", {31'b0, resp_err}, {31'b0, err});
    check_eq("n_reads", 32'(reads), 32'(exp_reads));
    check_eq("n_writes", 32'(writes), 32'(exp_writes));

    @(negedge clk);
    check_eq("ready_back", {31'b0, req_ready}, 32'd1);
    check_eq("valid_clear", {31'b0, resp_valid}, 32'd0);
    check_eq("rdata_clear", resp_rdata, 32'd0);
    check_eq("err_clear", {31'b0, resp_err}, 32'd0);
    check_eq("mem_word", mem[idx], exp_word);
  endtask

  task automatic back_to_back();
    logic [4:0] pulses;
    wait_ready();
    pulses = '0;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0000_0010; req_wdata = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      pulses[k-1] = resp_valid;
      if (k == 3) check_eq("b2b_ready", {31'b0, req_ready}, 32'd1);
      if (k == 4) check_eq("b2b_rdata", resp_rdata, 32'd0);
    end
    req_valid = 1'b0;
    check_eq("b2b_pulses", {27'b0, pulses}, 32'b10010);
    @(negedge clk);
    check_eq("b2b_idle", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic reset_during_rmw();
    logic [5:0] idx;
    idx = 6'd12;
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0000_0031; req_wdata = 32'h0000_00A5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_rmw_rd", {31'b0, mem_read_en}, 32'd1);
    @(negedge clk);
    check_eq("rst_rmw_wr", {31'b0, mem_write_en}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_wen", {31'b0, mem_write_en}, 32'd0);
    check_eq("rst_ren", {31'b0, mem_read_en}, 32'd0);
    check_eq("rst_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("rst_maddr", mem_addr, 32'd0);
    check_eq("rst_wdata", mem_write_data, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check_eq("rst_mem_kept", mem[idx], ref_word(idx));
    @(negedge clk);
    check_eq("rst_idle", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    // Preload both memories while reset is held
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pre_we = 1'b1;
      pre_idx = 6'(i);
      pre_data = (i == 4) ? 32'h8899_AABB : $urandom;
      {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]} = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;

    check_eq("reset_ready", {31'b0, req_ready}, 32'd1);
    check_eq("reset_valid", {31'b0, resp_valid}, 32'd0);
    check_eq("reset_rdata", resp_rdata, 32'd0);
    check_eq("reset_err", {31'b0, resp_err}, 32'd0);
    check_eq("reset_ren", {31'b0, mem_read_en}, 32'd0);
    check_eq("reset_wen", {31'b0, mem_write_en}, 32'd0);
    check_eq("reset_maddr", mem_addr, 32'd0);
    check_eq("reset_wdata", mem_write_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_req(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0);
    run_req(1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0);
    run_req(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hCAFE_F00D);
    run_req(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0);
    run_req(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_005A);
    run_req(1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'h0);
    run_req(1'b0, 2'b01, 1'b0, 32'h0000_0021, 32'h0);
    run_req(1'b1, 2'b10, 1'b0, 32'h0000_0026, 32'h1234_5678);
    run_req(1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0);
    run_req(1'b1, 2'b11, 1'b0, 32'h0000_0044, 32'hFFFF_FFFF);
    run_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0);

    for (int n = 0; n < 200; n++)
      run_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom);

    back_to_back();
    reset_during_rmw();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
